// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single mem/sram access port between N_REQ requesters using a
//   round-robin grant with a per-owner burst lock. While another requester is
//   waiting, an owner gets at most MAX_BURST beats per grant (0 = unlimited).
//   The mem_* outputs drive the memory directly from the current owner.
//
// Parameters
//   N_REQ      number of requesters (2..4)
//   MAX_BURST  max beats per grant while another requester waits; 0 = unlimited
//   CNT_W      beat-counter width, must hold MAX_BURST
//
// Ports
//   clk, rst      clock; synchronous active-low reset
//   req_i         per-requester request, held high for the whole burst
//   req_we_i      per-requester write enable
//   req_addr_i    flattened 32-bit addresses (requester k at [32k+31:32k])
//   req_width_i   flattened 4-bit byte widths
//   req_data_i    flattened 32-bit write data
//   gnt_o         registered one-hot grant
//   ack_o         beat completed this cycle (gnt_o & req_i)
//   rdata_o       read data from memory, valid while ack_o is set
//   busy_o        arbiter is in GRANT
//   mem_*_o       memory command outputs; mem_data_i is the memory read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    req_we_i,
  input  logic [N_REQ*32-1:0] req_addr_i,
  input  logic [N_REQ*4-1:0]  req_width_i,
  input  logic [N_REQ*32-1:0] req_data_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    ack_o,
  output logic [31:0]         rdata_o,
  output logic                busy_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [3:0]          mem_width_o,
  output logic [31:0]         mem_data_o,
  input  logic [31:0]         mem_data_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter stops here; with an unlimited burst it simply parks at all-ones.
  localparam logic [CNT_W-1:0] SAT  = (MAX_BURST == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic             beat;
  logic             other_pend;
  logic             limit_hit;
  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] pick_idle;
  logic [IDX_W-1:0] pick_other;
  logic [N_REQ-1:0] others;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // First set bit of mask scanning start, start+1, ... wrapping at N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDX_W'((int'(start) + i) % N_REQ);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign ack_o  = gnt_o & req_i;
  assign beat   = |ack_o;
  assign busy_o = (state == GRANT);

  // Scanning from owner+1 with the owner masked out serves both release cases:
  // a dropped request is already clear, and a limit release must skip the owner.
  always_comb begin
    others     = req_i & ~onehot(owner);
    other_pend = |others;
    owner_next = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    pick_idle  = rr_pick(req_i, ptr);
    pick_other = rr_pick(others, owner_next);
    limit_hit  = (MAX_BURST != 0) && beat && (beat_cnt >= LAST);
  end

  // Arbitration FSM: grant, burst counting and release/hand-over.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_o    <= '0;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            state    <= GRANT;
            owner    <= pick_idle;
            gnt_o    <= onehot(pick_idle);
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (!beat) begin
            ptr      <= owner_next;
            beat_cnt <= '0;
            if (other_pend) begin
              owner <= pick_other;
              gnt_o <= onehot(pick_other);
            end else begin
              state <= IDLE;
              gnt_o <= '0;
            end
          end else if (limit_hit && other_pend) begin
            // Limit reached with someone waiting: this beat completes, then hand over.
            ptr      <= owner_next;
            owner    <= pick_other;
            gnt_o    <= onehot(pick_other);
            beat_cnt <= '0;
          end else if (beat_cnt != SAT) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

  // Memory command mux: only an acked owner reaches the memory port.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ack_o[k]) begin
        mem_ce_o    = 1'b1;
        mem_we_o    = req_we_i[k];
        mem_addr_o  = req_addr_i[32*k +: 32];
        mem_width_o = req_width_i[4*k +: 4];
        mem_data_o  = req_data_i[32*k +: 32];
      end
    end
  end

  assign rdata_o = beat ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Two-requester bench for mem_arbiter (MAX_BURST=4) with a combinational-read,
//   clocked-write word memory model behind the mem_* port.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int N_REQ     = 2;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 5;

  localparam logic [31:0] A10  = 32'h10;
  localparam logic [31:0] A20  = 32'h20;
  localparam logic [31:0] A24  = 32'h24;
  localparam logic [31:0] IMG4 = 32'hA500_0004;
  localparam logic [31:0] IMG8 = 32'hA500_0008;
  localparam logic [31:0] IMG9 = 32'hA500_0009;
  localparam logic [31:0] DB   = 32'hDEAD_BEEF;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N_REQ-1:0]    req_i = '0;
  logic [N_REQ-1:0]    req_we_i = '0;
  logic [N_REQ*32-1:0] req_addr_i = '0;
  logic [N_REQ*4-1:0]  req_width_i = '0;
  logic [N_REQ*32-1:0] req_data_i = '0;
  logic [N_REQ-1:0]    gnt_o;
  logic [N_REQ-1:0]    ack_o;
  logic [31:0]         rdata_o;
  logic                busy_o;
  logic                mem_ce_o;
  logic                mem_we_o;
  logic [31:0]         mem_addr_o;
  logic [3:0]          mem_width_o;
  logic [31:0]         mem_data_o;
  logic [31:0]         mem_data_i;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_width_i(req_width_i), .req_data_i(req_data_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  // Memory model: image word i = 0xA500_0000 | i, reloaded while in reset.
  logic [31:0] mem [64];
  assign mem_data_i = mem[mem_addr_o[7:2]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_ce_o && mem_we_o) begin
      mem[mem_addr_o[7:2]] <= mem_data_o;
    end
  end

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mkv(string n, logic r, logic [1:0] req, logic [1:0] we,
                               logic [31:0] a0, logic [31:0] a1, logic [31:0] d1,
                               logic [1:0] g, logic [1:0] a, logic [31:0] rd);
    vec_t v;
    v.name = n; v.rst = r; v.req = req; v.we = we;
    v.a0 = a0; v.a1 = a1; v.d1 = d1;
    v.gnt = g; v.ack = a; v.rdata = rd;
    return v;
  endfunction

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s.%s got=%h exp=%h at %0t", name, field, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the clock edge and queue its expectation.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst         = v.rst;
    req_i       = v.req;
    req_we_i    = v.we;
    req_addr_i  = {v.a1, v.a0};
    req_data_i  = {v.d1, 32'h0};
    req_width_i = {4'd4, 4'd4};
    sb.push_back(v);
  endtask

  // Compare DUT outputs against the oldest queued expectation on the falling edge.
  task automatic checkOutput();
    vec_t        e;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    @(negedge clk);
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard got=empty exp=entry");
      return;
    end
    e = sb.pop_front();
    vectors++;
    exp_addr = e.ack[1] ? e.a1 : (e.ack[0] ? e.a0 : 32'h0);
    exp_data = e.ack[1] ? e.d1 : 32'h0;
    cmp(e.name, "gnt",   32'(gnt_o),       32'(e.gnt));
    cmp(e.name, "ack",   32'(ack_o),       32'(e.ack));
    cmp(e.name, "busy",  32'(busy_o),      32'(|e.gnt));
    cmp(e.name, "ce",    32'(mem_ce_o),    32'(|e.ack));
    cmp(e.name, "we",    32'(mem_we_o),    32'(|(e.ack & e.we)));
    cmp(e.name, "addr",  mem_addr_o,       exp_addr);
    cmp(e.name, "width", 32'(mem_width_o), (|e.ack) ? 32'd4 : 32'd0);
    cmp(e.name, "wdata", mem_data_o,       exp_data);
    if ((e.ack & ~e.we) != 2'b00) cmp(e.name, "rdata", rdata_o, e.rdata);
  endtask

  task automatic run(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  // Structural invariants on every out-of-reset cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_ce_o && ack_o == '0) begin
        miscompares++;
        $display("[TB] FAIL ce_without_ack got=ce1/ack%b exp=no ce", ack_o);
      end
      if (!$onehot0(gnt_o)) begin
        miscompares++;
        $display("[TB] FAIL gnt_onehot got=%b exp=onehot0", gnt_o);
      end
      if ((ack_o & ~gnt_o) != '0) begin
        miscompares++;
        $display("[TB] FAIL ack_subset got=ack%b/gnt%b exp=ack within gnt", ack_o, gnt_o);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with both requests, then a single read, round-robin hand-over,
    // and a cross-owner write-then-read.
    for (int i = 0; i < 3; i++) tbl.push_back(mkv("reset", 0, 2'b11, 2'b00, A10, A20, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mkv("idle",       1, 2'b00, 2'b00, A10, A20, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mkv("rd_wait",    1, 2'b01, 2'b00, A10, A20, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mkv("rd_ack",     1, 2'b01, 2'b00, A10, A20, 0,  2'b01, 2'b01, IMG4));
    tbl.push_back(mkv("rd_drop",    1, 2'b00, 2'b00, A10, A20, 0,  2'b01, 2'b00, 0));
    tbl.push_back(mkv("rd_idle",    1, 2'b00, 2'b00, A10, A20, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mkv("rr_rst",     0, 2'b11, 2'b00, A10, A20, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mkv("rr_rel",     1, 2'b11, 2'b00, A10, A20, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mkv("rr_r0",      1, 2'b11, 2'b00, A10, A20, 0,  2'b01, 2'b01, IMG4));
    tbl.push_back(mkv("rr_drop0",   1, 2'b10, 2'b00, A10, A20, 0,  2'b01, 2'b00, 0));
    tbl.push_back(mkv("rr_r1",      1, 2'b10, 2'b00, A10, A20, 0,  2'b10, 2'b10, IMG8));
    tbl.push_back(mkv("rr_end",     1, 2'b00, 2'b00, A10, A20, 0,  2'b10, 2'b00, 0));
    tbl.push_back(mkv("rr_idle",    1, 2'b00, 2'b00, A10, A20, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mkv("wr_wait",    1, 2'b10, 2'b10, A20, A20, DB, 2'b00, 2'b00, 0));
    tbl.push_back(mkv("wr_ack",     1, 2'b10, 2'b10, A20, A20, DB, 2'b10, 2'b10, 0));
    tbl.push_back(mkv("wr_drop",    1, 2'b01, 2'b00, A20, A20, 0,  2'b10, 2'b00, 0));
    tbl.push_back(mkv("rb_ack",     1, 2'b01, 2'b00, A20, A20, 0,  2'b01, 2'b01, DB));
    tbl.push_back(mkv("rb_end",     1, 2'b00, 2'b00, A20, A20, 0,  2'b01, 2'b00, 0));
    tbl.push_back(mkv("rb_idle",    1, 2'b00, 2'b00, A20, A20, 0,  2'b00, 2'b00, 0));

    $display("[TB] applying %0d table vectors", tbl.size());
    foreach (tbl[i]) run(tbl[i]);

    // Fairness: req0 alone is granted, req1 joins; req0 gets exactly 4 beats.
    run(mkv("fair_pre", 1, 2'b01, 2'b00, A10, A24, 0, 2'b00, 2'b00, 0));
    for (int k = 0; k < MAX_BURST; k++)
      run(mkv("fair_r0", 1, 2'b11, 2'b00, A10, A24, 0, 2'b01, 2'b01, IMG4));
    for (int k = 0; k < 2; k++)
      run(mkv("fair_r1", 1, 2'b11, 2'b00, A10, A24, 0, 2'b10, 2'b10, IMG9));
    run(mkv("fair_drop1", 1, 2'b01, 2'b00, A10, A24, 0, 2'b10, 2'b00, 0));

    // Lone long burst: grant returns to req0 and holds for 40 beats.
    for (int k = 0; k < 40; k++)
      run(mkv("burst", 1, 2'b01, 2'b00, A10, A24, 0, 2'b01, 2'b01, IMG4));
    run(mkv("burst_end",  1, 2'b00, 2'b00, A10, A24, 0, 2'b01, 2'b00, 0));
    run(mkv("burst_idle", 1, 2'b00, 2'b00, A10, A24, 0, 2'b00, 2'b00, 0));

    // Reset asserted mid-burst drops the grant at the next edge.
    run(mkv("mr_wait",    1, 2'b01, 2'b00, A10, A24, 0, 2'b00, 2'b00, 0));
    run(mkv("mr_beat",    1, 2'b01, 2'b00, A10, A24, 0, 2'b01, 2'b01, IMG4));
    run(mkv("mr_rst",     0, 2'b01, 2'b00, A10, A24, 0, 2'b01, 2'b01, IMG4));
    run(mkv("mr_after",   1, 2'b01, 2'b00, A10, A24, 0, 2'b00, 2'b00, 0));
    run(mkv("mr_regrant", 1, 2'b01, 2'b00, A10, A24, 0, 2'b01, 2'b01, IMG4));

    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
